// File: rtl/sd_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// sd_pkg - shared encodings for the SPI-mode SD command engine (rev 1.0)
//------------------------------------------------------------------------------
package sd_pkg;

  localparam logic [1:0] RESP_R1      = 2'd0;
  localparam logic [1:0] RESP_R1_EXT  = 2'd1;
  localparam logic [1:0] RESP_R1_DATA = 2'd2;
  localparam logic [1:0] RESP_RSVD    = 2'd3;

  localparam logic [7:0] DATA_TOKEN = 8'hFE;
  localparam logic [1:0] START_BITS = 2'b01;
  localparam logic       END_BIT    = 1'b1;

  typedef enum logic [3:0] {
    IDLE,
    SEND,
    WAIT_R1,
    RX_R1,
    RX_EXT,
    WAIT_TOKEN,
    RX_DATA,
    RX_CRC,
    TRAIL
  } state_t;

endpackage
`default_nettype wire

// File: rtl/sd_crc7.sv
`default_nettype none
//------------------------------------------------------------------------------
// sd_crc7 - serial CRC7 (x^7 + x^3 + 1), MSB-first input (rev 1.0)
//------------------------------------------------------------------------------
module sd_crc7 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       enable,
  input  logic       din,
  output logic [6:0] crc
);

  logic fb;
  assign fb = din ^ crc[6];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc <= 7'h00;
    end else if (clear) begin
      crc <= 7'h00;
    end else if (enable) begin
      crc <= {crc[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
    end
  end

endmodule
`default_nettype wire

// File: rtl/sd_spi_cmd_engine.sv
`default_nettype none
//------------------------------------------------------------------------------
// sd_spi_cmd_engine - SPI-mode SD command/response engine (rev 1.0)
//------------------------------------------------------------------------------
module sd_spi_cmd_engine
  import sd_pkg::*;
#(
  parameter int CLK_DIV     = 4,
  parameter int NCR_MAX     = 64,
  parameter int TOKEN_MAX   = 8192,
  parameter int BLOCK_BYTES = 512
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  input  logic [1:0]  resp_type,
  output logic        resp_valid,
  output logic        resp_timeout,
  output logic [7:0]  resp_r1,
  output logic [31:0] resp_ext,
  output logic        rd_valid,
  output logic [7:0]  rd_data,
  output logic        sd_clk,
  output logic        sd_cs_n,
  output logic        sd_mosi,
  input  logic        sd_miso
);

  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BYTE_W = $clog2(BLOCK_BYTES);
  localparam int NCR_W  = $clog2(NCR_MAX) + 1;
  localparam int TOK_W  = $clog2(TOKEN_MAX) + 1;

  state_t            state, state_next;
  logic [DIV_W-1:0]  div_cnt;
  logic [5:0]        bit_cnt;
  logic [BYTE_W-1:0] byte_cnt;
  logic [NCR_W-1:0]  ncr_cnt;
  logic [TOK_W-1:0]  tok_cnt;
  logic [39:0]       hdr;
  logic [1:0]        rtype;
  logic [7:0]        window;
  logic [6:0]        data_sh;
  logic              miso_meta, miso_s;
  logic [6:0]        crc;

  logic        tick, rise, fall, accept;
  logic [47:0] frame;
  logic [7:0]  r1_full, window_next;
  logic        r1_ok, token_hit, ncr_expired, tok_expired, last_byte;

  assign tick        = (state != IDLE) && (div_cnt == DIV_W'(CLK_DIV - 1));
  assign rise        = tick & ~sd_clk;
  assign fall        = tick & sd_clk;
  assign accept      = cmd_valid & cmd_ready;
  assign frame       = {hdr, crc, END_BIT};
  assign r1_full     = {resp_r1[6:0], miso_s};
  assign window_next = {window[6:0], miso_s};
  assign r1_ok       = (r1_full == 8'h00) || (r1_full == 8'h01);
  assign token_hit   = (window_next == DATA_TOKEN);
  assign ncr_expired = (ncr_cnt == NCR_W'(NCR_MAX - 1));
  assign tok_expired = (tok_cnt == TOK_W'(TOKEN_MAX - 1));
  assign last_byte   = (byte_cnt == BYTE_W'(BLOCK_BYTES - 1));

  // CRC follows the bits actually driven, so it is complete before bit 40 leaves
  sd_crc7 u_crc7 (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (accept),
    .enable (rise && (state == SEND) && (bit_cnt < 6'd40)),
    .din    (sd_mosi),
    .crc    (crc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miso_meta <= 1'b1;
      miso_s    <= 1'b1;
      div_cnt   <= '0;
      state     <= IDLE;
    end else begin
      miso_meta <= sd_miso;
      miso_s    <= miso_meta;
      div_cnt   <= (state == IDLE || tick) ? '0 : div_cnt + DIV_W'(1);
      state     <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:       if (accept) state_next = SEND;
      SEND:       if (fall && bit_cnt == 6'd47) state_next = WAIT_R1;
      WAIT_R1:    if (rise) begin
                    if (!miso_s)          state_next = RX_R1;
                    else if (ncr_expired) state_next = TRAIL;
                  end
      RX_R1:      if (rise && bit_cnt == 6'd7) begin
                    if (rtype == RESP_R1_EXT)                state_next = RX_EXT;
                    else if (rtype == RESP_R1_DATA && r1_ok) state_next = WAIT_TOKEN;
                    else                                     state_next = TRAIL;
                  end
      RX_EXT:     if (rise && bit_cnt == 6'd31) state_next = TRAIL;
      WAIT_TOKEN: if (rise) begin
                    if (token_hit)        state_next = RX_DATA;
                    else if (tok_expired) state_next = TRAIL;
                  end
      RX_DATA:    if (rise && bit_cnt == 6'd7 && last_byte) state_next = RX_CRC;
      RX_CRC:     if (rise && bit_cnt == 6'd15) state_next = TRAIL;
      TRAIL:      if (fall && bit_cnt == 6'd8) state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_ready    <= 1'b1;
      resp_valid   <= 1'b0;
      resp_timeout <= 1'b0;
      resp_r1      <= 8'hFF;
      resp_ext     <= '0;
      rd_valid     <= 1'b0;
      rd_data      <= '0;
      sd_clk       <= 1'b0;
      sd_cs_n      <= 1'b1;
      sd_mosi      <= 1'b1;
      hdr          <= '0;
      rtype        <= RESP_R1;
      bit_cnt      <= '0;
      byte_cnt     <= '0;
      ncr_cnt      <= '0;
      tok_cnt      <= '0;
      window       <= '0;
      data_sh      <= '0;
    end else begin
      resp_valid <= 1'b0;
      rd_valid   <= 1'b0;
      if (rise)      sd_clk <= 1'b1;
      else if (fall) sd_clk <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          cmd_ready    <= 1'b0;
          sd_cs_n      <= 1'b0;
          sd_mosi      <= START_BITS[1];
          hdr          <= {START_BITS, cmd_index, cmd_arg};
          rtype        <= (resp_type == RESP_RSVD) ? RESP_R1 : resp_type;
          resp_r1      <= 8'hFF;
          resp_ext     <= '0;
          resp_timeout <= 1'b0;
          bit_cnt      <= '0;
          byte_cnt     <= '0;
          ncr_cnt      <= '0;
          tok_cnt      <= '0;
          window       <= '0;
        end
        SEND: if (fall) begin
          if (bit_cnt == 6'd47) begin
            sd_mosi <= 1'b1;
            bit_cnt <= '0;
          end else begin
            sd_mosi <= frame[6'd46 - bit_cnt];
            bit_cnt <= bit_cnt + 6'd1;
          end
        end
        WAIT_R1: if (rise) begin
          if (!miso_s) begin
            resp_r1 <= r1_full;
            bit_cnt <= 6'd1;
          end else if (ncr_expired) begin
            resp_r1      <= 8'hFF;
            resp_timeout <= 1'b1;
            bit_cnt      <= '0;
          end else begin
            ncr_cnt <= ncr_cnt + NCR_W'(1);
          end
        end
        RX_R1: if (rise) begin
          resp_r1 <= r1_full;
          bit_cnt <= (bit_cnt == 6'd7) ? 6'd0 : bit_cnt + 6'd1;
        end
        RX_EXT: if (rise) begin
          resp_ext <= {resp_ext[30:0], miso_s};
          bit_cnt  <= (bit_cnt == 6'd31) ? 6'd0 : bit_cnt + 6'd1;
        end
        WAIT_TOKEN: if (rise) begin
          window <= window_next;
          if (!token_hit) begin
            if (tok_expired) resp_timeout <= 1'b1;
            else             tok_cnt      <= tok_cnt + TOK_W'(1);
          end
        end
        RX_DATA: if (rise) begin
          data_sh <= {data_sh[5:0], miso_s};
          if (bit_cnt == 6'd7) begin
            rd_valid <= 1'b1;
            rd_data  <= {data_sh, miso_s};
            bit_cnt  <= '0;
            byte_cnt <= last_byte ? '0 : byte_cnt + BYTE_W'(1);
          end else begin
            bit_cnt <= bit_cnt + 6'd1;
          end
        end
        RX_CRC: if (rise) begin
          resp_ext[15:0] <= {resp_ext[14:0], miso_s};
          bit_cnt        <= (bit_cnt == 6'd15) ? 6'd0 : bit_cnt + 6'd1;
        end
        TRAIL: begin
          // every entry to TRAIL happens on a rise, so eight rises then one fall
          if (rise) begin
            bit_cnt <= bit_cnt + 6'd1;
          end else if (fall && bit_cnt == 6'd8) begin
            sd_cs_n    <= 1'b1;
            resp_valid <= 1'b1;
            cmd_ready  <= 1'b1;
            bit_cnt    <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sd_spi_cmd_engine.sv
`default_nettype none
//------------------------------------------------------------------------------
// tb_sd_spi_cmd_engine - directed bench with card model and response model (rev 1.0)
//------------------------------------------------------------------------------
module tb_sd_spi_cmd_engine;

  localparam int CLK_DIV     = 4;
  localparam int NCR_MAX     = 64;
  localparam int TOKEN_MAX   = 8192;
  localparam int BLOCK_BYTES = 512;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic [1:0]  resp_type;
  logic        resp_valid;
  logic        resp_timeout;
  logic [7:0]  resp_r1;
  logic [31:0] resp_ext;
  logic        rd_valid;
  logic [7:0]  rd_data;
  logic        sd_clk;
  logic        sd_cs_n;
  logic        sd_mosi;
  logic        sd_miso = 1'b1;

  sd_spi_cmd_engine #(
    .CLK_DIV(CLK_DIV), .NCR_MAX(NCR_MAX), .TOKEN_MAX(TOKEN_MAX), .BLOCK_BYTES(BLOCK_BYTES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_index(cmd_index), .cmd_arg(cmd_arg), .resp_type(resp_type),
    .resp_valid(resp_valid), .resp_timeout(resp_timeout), .resp_r1(resp_r1),
    .resp_ext(resp_ext), .rd_valid(rd_valid), .rd_data(rd_data),
    .sd_clk(sd_clk), .sd_cs_n(sd_cs_n), .sd_mosi(sd_mosi), .sd_miso(sd_miso)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Card: records the command frame, then shifts resp_bits out on falling sd_clk
  bit          resp_bits[$];
  logic [47:0] card_frame = '0;
  int          card_rises = 0;
  int          last_rises = 0;
  int          card_idx   = 0;
  int          mosi_bad   = 0;

  always @(sd_clk or sd_cs_n) begin
    #1;
    if (sd_cs_n) begin
      if (card_rises != 0) last_rises = card_rises;
      card_rises = 0;
      card_idx   = 0;
      sd_miso    = 1'b1;
    end else if (sd_clk) begin
      if (card_rises < 48) card_frame = {card_frame[46:0], sd_mosi};
      else if (sd_mosi !== 1'b1) mosi_bad++;
      card_rises++;
    end else if (card_rises >= 48) begin
      sd_miso = (card_idx < resp_bits.size()) ? resp_bits[card_idx] : 1'b1;
      card_idx++;
    end
  end

  task automatic push_ones(input int n);
    for (int i = 0; i < n; i++) resp_bits.push_back(1'b1);
  endtask

  task automatic push_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) resp_bits.push_back(b[i]);
  endtask

  // Model: what the engine must report, given the bit stream the card sends
  logic [7:0]  m_r1;
  bit          m_to;
  logic [31:0] m_ext;
  int          m_used;
  logic [7:0]  m_bytes[$];

  function automatic bit bit_at(input int k);
    return (k < resp_bits.size()) ? resp_bits[k] : 1'b1;
  endfunction

  function automatic logic [6:0] crc7_of(input logic [39:0] m);
    logic [46:0] r;
    r = {m, 7'b0};
    for (int i = 46; i >= 7; i--) if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    return r[6:0];
  endfunction

  task automatic model_response(input logic [1:0] typ);
    int p;
    logic [7:0] w;
    bit found;
    m_r1 = 8'hFF; m_to = 1'b0; m_ext = '0; m_bytes.delete();
    p = 0;
    while (p < NCR_MAX && bit_at(p)) p++;
    if (p == NCR_MAX) begin
      m_to = 1'b1; m_used = NCR_MAX;
      return;
    end
    for (int i = 0; i < 8; i++) m_r1[7-i] = bit_at(p + i);
    p += 8;
    if (typ == 2'd1) begin
      for (int i = 0; i < 32; i++) m_ext[31-i] = bit_at(p + i);
      p += 32;
    end else if (typ == 2'd2 && (m_r1 == 8'h00 || m_r1 == 8'h01)) begin
      w = 8'h00; found = 1'b0;
      for (int n = 0; n < TOKEN_MAX && !found; n++) begin
        w = {w[6:0], bit_at(p)}; p++;
        found = (w == 8'hFE);
      end
      if (!found) m_to = 1'b1;
      else begin
        for (int b = 0; b < BLOCK_BYTES; b++) begin
          for (int i = 0; i < 8; i++) w[7-i] = bit_at(p + i);
          m_bytes.push_back(w); p += 8;
        end
        for (int i = 0; i < 16; i++) m_ext[15-i] = bit_at(p + i);
        p += 16;
      end
    end
    m_used = p;
  endtask

  task automatic run_txn(input string tag, input logic [5:0] idx, input logic [31:0] arg,
                         input logic [1:0] typ, input int busy_at, input int abort_byte);
    logic [1:0]  te;
    logic [47:0] exp_frame;
    int nrd, bad0, stray;
    bit done;
    te = (typ == 2'd3) ? 2'd0 : typ;
    model_response(te);
    exp_frame = {2'b01, idx, arg, crc7_of({2'b01, idx, arg}), 1'b1};
    bad0 = mosi_bad;
    @(negedge clk);
    cmd_index = idx; cmd_arg = arg; resp_type = typ; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    check({tag, "_accept"}, {62'd0, cmd_ready, sd_cs_n}, 64'd0);
    nrd = 0; done = 1'b0;
    for (int cyc = 0; cyc < 60000 && !done; cyc++) begin
      @(negedge clk);
      cmd_valid = (cyc == busy_at);
      if (rd_valid) begin
        if (nrd < m_bytes.size()) check({tag, "_rd_data"}, {56'd0, rd_data}, {56'd0, m_bytes[nrd]});
        else check({tag, "_extra_rd_valid"}, 64'd1, 64'd0);
        nrd++;
        if (abort_byte >= 0 && nrd == abort_byte) begin
          cmd_valid = 1'b0;
          repeat (20) @(negedge clk);
          rst_n = 1'b0;
          #1;
          check({tag, "_rst_cs_clk_rdy"}, {61'd0, sd_cs_n, sd_clk, cmd_ready}, 64'h5);
          check({tag, "_rst_pulses"}, {62'd0, rd_valid, resp_valid}, 64'd0);
          check({tag, "_rst_r1"}, {56'd0, resp_r1}, 64'hFF);
          repeat (3) @(negedge clk);
          rst_n = 1'b1;
          stray = 0;
          repeat (3000) begin
            @(negedge clk);
            if (rd_valid || resp_valid || !sd_cs_n) stray++;
          end
          check({tag, "_after_reset_quiet"}, 64'(stray), 64'd0);
          done = 1'b1;
        end
      end
      if (resp_valid && !done) begin
        done = 1'b1;
        check({tag, "_r1"}, {56'd0, resp_r1}, {56'd0, m_r1});
        check({tag, "_timeout"}, {63'd0, resp_timeout}, {63'd0, m_to});
        if (!m_to && (te == 2'd1 || m_bytes.size() > 0))
          check({tag, "_ext"}, {32'd0, resp_ext}, {32'd0, m_ext});
        check({tag, "_rd_count"}, 64'(nrd), 64'(m_bytes.size()));
        check({tag, "_frame"}, {16'd0, card_frame}, {16'd0, exp_frame});
        check({tag, "_sdclk_rises"}, 64'(last_rises), 64'(48 + m_used + 8));
        check({tag, "_mosi_idle_high"}, 64'(mosi_bad - bad0), 64'd0);
        check({tag, "_end_rdy_cs_clk"}, {61'd0, cmd_ready, sd_cs_n, sd_clk}, 64'h6);
        @(negedge clk);
        check({tag, "_resp_pulse_once"}, {63'd0, resp_valid}, 64'd0);
      end
    end
    cmd_valid = 1'b0;
    if (!done) check({tag, "_resp_valid_seen"}, 64'd0, 64'd1);
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_index = '0; cmd_arg = '0; resp_type = '0;
    repeat (3) @(negedge clk);
    check("reset_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    check("reset_resp_valid", {63'd0, resp_valid}, 64'd0);
    check("reset_resp_timeout", {63'd0, resp_timeout}, 64'd0);
    check("reset_resp_r1", {56'd0, resp_r1}, 64'hFF);
    check("reset_resp_ext", {32'd0, resp_ext}, 64'd0);
    check("reset_rd", {55'd0, rd_valid, rd_data}, 64'd0);
    check("reset_pins_clk_cs_mosi", {61'd0, sd_clk, sd_cs_n, sd_mosi}, 64'h3);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    resp_bits.delete(); push_ones(10); push_byte(8'h01);
    run_txn("cmd0", 6'd0, 32'h0, 2'd0, -1, -1);
    check("cmd0_frame_literal", {16'd0, card_frame}, 64'h400000000095);
    check("cmd0_rises_literal", 64'(last_rises), 64'd74);

    resp_bits.delete(); push_ones(3); push_byte(8'h01);
    push_byte(8'h00); push_byte(8'h00); push_byte(8'h01); push_byte(8'hAA);
    run_txn("cmd8", 6'd8, 32'h000001AA, 2'd1, -1, -1);
    check("cmd8_frame_literal", {16'd0, card_frame}, 64'h48000001AA87);
    check("cmd8_ext_literal", {32'd0, resp_ext}, 64'h1AA);

    resp_bits.delete(); push_ones(5); push_byte(8'h00); push_ones(20); push_byte(8'hFE);
    for (int i = 0; i < BLOCK_BYTES; i++) push_byte(8'(i));
    push_byte(8'hBE); push_byte(8'hEF);
    run_txn("cmd17", 6'd17, 32'h0, 2'd2, 200, -1);
    check("cmd17_ext_literal", {32'd0, resp_ext}, 64'h0000BEEF);

    resp_bits.delete();
    run_txn("cmd55_ncr", 6'd55, 32'h0, 2'd0, -1, -1);
    check("cmd55_rises_literal", 64'(last_rises), 64'd120);
    check("cmd55_timeout_literal", {55'd0, resp_timeout, resp_r1}, 64'h1FF);

    resp_bits.delete(); push_ones(2); push_byte(8'h04); push_ones(20); push_byte(8'hFE);
    for (int i = 0; i < 4; i++) push_byte(8'h5A);
    run_txn("cmd17_err", 6'd17, 32'h0, 2'd2, -1, -1);
    check("cmd17_err_literal", {55'd0, resp_timeout, resp_r1}, 64'h004);

    resp_bits.delete(); push_ones(4); push_byte(8'h01); push_byte(8'hC0); push_byte(8'hFF);
    run_txn("cmd58_rsvd", 6'd58, 32'h0, 2'd3, -1, -1);

    resp_bits.delete(); push_ones(7); push_byte(8'h00); push_ones(9); push_byte(8'hFE);
    for (int i = 0; i < BLOCK_BYTES; i++) push_byte(8'(i * 3));
    run_txn("cmd17_rst", 6'd17, 32'h00000200, 2'd2, 1000, 100);

    resp_bits.delete(); push_ones(1); push_byte(8'h01);
    run_txn("cmd0_again", 6'd0, 32'h0, 2'd0, -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
